// File: rtl/riscv_i32_pipeline_fetch_sequencer_pkg.sv
// Shared definitions for the i32 fetch sequencer: fetch action encodings,
// privilege mode constants, sequencer state enum and the RUN-state action rule.
package riscv_i32_pipeline_fetch_sequencer_pkg;

  // Encodings seen by the fetch-request builder on the fetch_action field.
  // NEXT_NONSEQ is part of the builder's vocabulary but is not issued here.
  typedef enum logic [2:0] {
    ACT_IDLE_FLUSH  = 3'd0,
    ACT_HOLD        = 3'd1,
    ACT_RESTART     = 3'd2,
    ACT_NEXT_NONSEQ = 3'd3,
    ACT_NEXT        = 3'd4
  } fetch_action_e;

  localparam logic [2:0] MODE_MACHINE = 3'd3;
  localparam logic [2:0] MODE_DEBUG   = 3'd7;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_RESTART  = 3'd1,
    ST_RUN      = 3'd2,
    ST_HALTING  = 3'd3,
    ST_HALTED   = 3'd4
  } seq_state_e;

  // Steady-state action: advance only when an instruction is present and
  // decode takes it without a hazard; otherwise keep the fetch stream parked.
  function automatic fetch_action_e run_action(input logic ifetch_valid,
                                               input logic decode_accept,
                                               input logic decode_blocked);
    if (ifetch_valid && decode_accept && !decode_blocked) return ACT_NEXT;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/riscv_i32_pipeline_fetch_sequencer_if.sv
// Bundle of the sequencer's pipeline-side inputs and fetch-control outputs.
//
// Handshake semantics: ifetch_valid means an instruction for decode_pc is
// present this cycle; decode_accept means decode consumed it in the same
// cycle; decode_blocked vetoes consumption. exec_redirect, trap_valid and
// dbg_resume_req are single-cycle strobes; dbg_halt_req is a level. All
// outputs are registered: an input seen at cycle N shows up at cycle N+1.
interface riscv_i32_pipeline_fetch_sequencer_if;
  import riscv_i32_pipeline_fetch_sequencer_pkg::*;

  logic        ifetch_valid;
  logic        decode_accept;
  logic        decode_blocked;
  logic        exec_redirect;
  logic [31:0] exec_redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [2:0]  trap_to_mode;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic [31:0] dbg_resume_pc;

  logic [2:0]  fetch_action;
  logic [31:0] decode_pc;
  logic [2:0]  mode;
  logic [1:0]  tag;
  logic        halted;
  seq_state_e  seq_state;

  // Pipeline / testbench side.
  modport master (
    output ifetch_valid, decode_accept, decode_blocked,
    output exec_redirect, exec_redirect_pc,
    output trap_valid, trap_pc, trap_to_mode,
    output dbg_halt_req, dbg_resume_req, dbg_resume_pc,
    input  fetch_action, decode_pc, mode, tag, halted, seq_state
  );

  // Sequencer side.
  modport slave (
    input  ifetch_valid, decode_accept, decode_blocked,
    input  exec_redirect, exec_redirect_pc,
    input  trap_valid, trap_pc, trap_to_mode,
    input  dbg_halt_req, dbg_resume_req, dbg_resume_pc,
    output fetch_action, decode_pc, mode, tag, halted, seq_state
  );

endinterface

// File: rtl/riscv_i32_fetch_start_counter.sv
// Reset start-up countdown: loads RESET_DELAY on reset, counts down while the
// sequencer sits in START, and flags the cycle whose edge reaches zero.
module riscv_i32_fetch_start_counter #(
  parameter int unsigned RESET_DELAY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic expire
);

  logic [3:0] count;

  // Countdown register; parks at zero once the start-up window is over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'(RESET_DELAY);
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  // The edge that takes the count from 1 to 0 is the edge that leaves START.
  assign expire = en && (count == 4'd1);

endmodule

// File: rtl/riscv_i32_pipeline_fetch_sequencer.sv
// Fetch sequencer for the i32 pipeline: picks the per-cycle fetch action and
// owns decode_pc, privilege mode and the 2-bit fetch epoch tag.
// Optional feature macro: RISCV_FETCH_SEQ_DEBUG_EN (debug halt/resume, mode 7).
module riscv_i32_pipeline_fetch_sequencer
  import riscv_i32_pipeline_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned RESET_DELAY  = 4
) (
  input logic clk,
  input logic reset,
  riscv_i32_pipeline_fetch_sequencer_if.slave bus
);

  seq_state_e    state_q, state_d;
  fetch_action_e action_q, action_d;
  logic [31:0]   pc_q, pc_d;
  logic [2:0]    mode_q, mode_d;
  logic [1:0]    tag_q, tag_d;
  logic          start_done;

`ifdef RISCV_FETCH_SEQ_DEBUG_EN
  logic          halted_q, halted_d;
  logic [2:0]    saved_mode_q, saved_mode_d;
`else
  logic          unused_dbg;
  assign unused_dbg = ^{bus.dbg_halt_req, bus.dbg_resume_req, bus.dbg_resume_pc};
`endif

  riscv_i32_fetch_start_counter #(
    .RESET_DELAY (RESET_DELAY)
  ) u_start_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == ST_START),
    .expire (start_done)
  );

  // Next-state and next-output decision; priority trap > redirect > halt > run.
  // decode_pc only moves on restarts: the builder tracks sequential PCs.
  always_comb begin
    state_d  = state_q;
    action_d = ACT_IDLE_FLUSH;
    pc_d     = pc_q;
    mode_d   = mode_q;
    tag_d    = tag_q;
`ifdef RISCV_FETCH_SEQ_DEBUG_EN
    halted_d     = halted_q;
    saved_mode_d = saved_mode_q;
`endif
    unique case (state_q)
      ST_START: begin
        if (start_done) begin
          state_d  = ST_RESTART;
          action_d = ACT_RESTART;
          pc_d     = RESET_VECTOR;
          mode_d   = MODE_MACHINE;
        end
      end
`ifdef RISCV_FETCH_SEQ_DEBUG_EN
      ST_HALTED: begin
        // Redirects and traps are meaningless while the core is parked.
        if (bus.dbg_resume_req) begin
          state_d  = ST_RESTART;
          action_d = ACT_RESTART;
          pc_d     = bus.dbg_resume_pc;
          mode_d   = saved_mode_q;
          tag_d    = tag_q + 2'd1;
          halted_d = 1'b0;
        end
      end
`endif
      default: begin
        // RESTART, RUN and HALTING all honour traps and redirects first.
        if (bus.trap_valid) begin
          state_d  = ST_RESTART;
          action_d = ACT_RESTART;
          pc_d     = bus.trap_pc;
          mode_d   = bus.trap_to_mode;
          tag_d    = tag_q + 2'd1;
        end else if (bus.exec_redirect) begin
          state_d  = ST_RESTART;
          action_d = ACT_RESTART;
          pc_d     = bus.exec_redirect_pc;
          tag_d    = tag_q + 2'd1;
        end
`ifdef RISCV_FETCH_SEQ_DEBUG_EN
        else if (state_q == ST_HALTING) begin
          // Keep flushing until decode has nothing left in flight.
          if (!bus.decode_accept) begin
            state_d      = ST_HALTED;
            saved_mode_d = mode_q;
            mode_d       = MODE_DEBUG;
            halted_d     = 1'b1;
          end
        end else if (bus.dbg_halt_req) begin
          state_d = ST_HALTING;
        end
`endif
        else begin
          state_d  = ST_RUN;
          action_d = run_action(bus.ifetch_valid, bus.decode_accept, bus.decode_blocked);
        end
      end
    endcase
  end

  // State and output registers; reset restores the start-up values at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_START;
      action_q <= ACT_IDLE_FLUSH;
      pc_q     <= RESET_VECTOR;
      mode_q   <= MODE_MACHINE;
      tag_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      pc_q     <= pc_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
    end
  end

`ifdef RISCV_FETCH_SEQ_DEBUG_EN
  // Debug-only state: halted flag and the mode to restore on resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q     <= 1'b0;
      saved_mode_q <= MODE_MACHINE;
    end else begin
      halted_q     <= halted_d;
      saved_mode_q <= saved_mode_d;
    end
  end
  assign bus.halted = halted_q;
`else
  assign bus.halted = 1'b0;
`endif

  assign bus.fetch_action = action_q;
  assign bus.decode_pc    = pc_q;
  assign bus.mode         = mode_q;
  assign bus.tag          = tag_q;
  assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_riscv_i32_pipeline_fetch_sequencer.sv
// Self-checking bench for riscv_i32_pipeline_fetch_sequencer. Honours
// RISCV_FETCH_SEQ_DEBUG_EN so the same file covers both builds.
module tb_riscv_i32_pipeline_fetch_sequencer;
  import riscv_i32_pipeline_fetch_sequencer_pkg::*;

  localparam logic [31:0] RV = 32'h0;
  localparam int          RD = 4;
  localparam int          EW = 41;
`ifdef RISCV_FETCH_SEQ_DEBUG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  typedef struct packed {
    logic        iv, acc, blk, redir;
    logic [31:0] rpc;
    logic        trap;
    logic [31:0] tpc;
    logic [2:0]  tmode;
    logic        hreq, res;
    logic [31:0] respc;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  riscv_i32_pipeline_fetch_sequencer_if bus ();

  riscv_i32_pipeline_fetch_sequencer #(
    .RESET_VECTOR (RV),
    .RESET_DELAY  (RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [EW-1:0] pack(input logic [2:0] act, input logic [31:0] pc,
                                         input logic [2:0] mode, input logic [1:0] tag,
                                         input logic halted);
    return {act, pc, mode, tag, halted};
  endfunction

  function automatic logic [EW-1:0] dut_out();
    return {bus.fetch_action, bus.decode_pc, bus.mode, bus.tag, bus.halted};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got act=%0d pc=%h mode=%0d tag=%0d halted=%0d, want act=%0d pc=%h mode=%0d tag=%0d halted=%0d",
               name, $time, got[40:38], got[37:6], got[5:3], got[2:1], got[0],
               exp[40:38], exp[37:6], exp[5:3], exp[2:1], exp[0]);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check("cycle", dut_out(), exp_q.pop_front());
  end

  // ---------------- reference model ----------------
  // Phases: boot countdown, restart, running, draining for halt, parked.
  localparam int P_BOOT = 0, P_RESTART = 1, P_RUN = 2, P_DRAIN = 3, P_PARKED = 4;
  int          m_phase, m_boot, m_epoch;
  logic [2:0]  m_act, m_mode, m_saved;
  logic [31:0] m_pc;
  logic        m_halted;

  function automatic logic [EW-1:0] model_pack();
    return pack(m_act, m_pc, m_mode, 2'(m_epoch % 4), m_halted);
  endfunction

  task automatic model_reset();
    m_phase = P_BOOT; m_boot = RD; m_epoch = 0;
    m_act = 3'd0; m_pc = RV; m_mode = 3'd3; m_saved = 3'd3; m_halted = 1'b0;
  endtask

  task automatic restart_to(input logic [31:0] pc);
    m_phase = P_RESTART; m_act = 3'd2; m_pc = pc; m_epoch++;
  endtask

  task automatic model_step(input stim_t s);
    if (m_phase == P_BOOT) begin
      m_boot--;
      m_act = 3'd0;
      if (m_boot == 0) begin
        m_phase = P_RESTART; m_act = 3'd2; m_pc = RV; m_mode = 3'd3;
      end
    end else if (m_phase == P_PARKED) begin
      m_act = 3'd0;
      if (s.res) begin
        restart_to(s.respc); m_mode = m_saved; m_halted = 1'b0;
      end
    end else if (s.trap) begin
      restart_to(s.tpc); m_mode = s.tmode;
    end else if (s.redir) begin
      restart_to(s.rpc);
    end else if (m_phase == P_DRAIN) begin
      m_act = 3'd0;
      if (!s.acc) begin
        m_phase = P_PARKED; m_saved = m_mode; m_mode = 3'd7; m_halted = 1'b1;
      end
    end else if (DBG_EN && s.hreq) begin
      m_phase = P_DRAIN; m_act = 3'd0;
    end else begin
      m_phase = P_RUN;
      m_act = (s.iv && s.acc && !s.blk) ? 3'd4 : 3'd1;
    end
  endtask

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.ifetch_valid     = s.iv;
    bus.decode_accept    = s.acc;
    bus.decode_blocked   = s.blk;
    bus.exec_redirect    = s.redir;
    bus.exec_redirect_pc = s.rpc;
    bus.trap_valid       = s.trap;
    bus.trap_pc          = s.tpc;
    bus.trap_to_mode     = s.tmode;
    bus.dbg_halt_req     = s.hreq;
    bus.dbg_resume_req   = s.res;
    bus.dbg_resume_pc    = s.respc;
  endtask

  // Called at a falling edge; drives one cycle, queues its expectation and
  // returns at the next falling edge with the outputs of that cycle settled.
  task automatic step(input stim_t s);
    apply(s);
    model_step(s);
    exp_q.push_back(model_pack());
    @(negedge clk);
  endtask

  task automatic do_reset(input bit mid_cycle);
    apply(idle());
    if (mid_cycle) begin
      @(posedge clk);
      #3;
    end
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_values", dut_out(), pack(3'd0, RV, 3'd3, 2'd0, 1'b0));
    repeat (2) @(negedge clk);
    check("reset_hold", dut_out(), pack(3'd0, RV, 3'd3, 2'd0, 1'b0));
    reset = 1'b0;
  endtask

  task automatic boot();
    for (int i = 0; i < RD; i++) step(idle());
    check("boot_restart", dut_out(), pack(3'd2, RV, 3'd3, 2'd0, 1'b0));
  endtask

  // ---------------- test sequence ----------------
  stim_t s;
  logic  hold_req;

  initial begin
    apply(idle());
    @(negedge clk);
    do_reset(1'b0);
    boot();
    step(idle());
    check("hold_no_ifetch", dut_out(), pack(3'd1, RV, 3'd3, 2'd0, 1'b0));

    s = idle(); s.iv = 1'b1; s.acc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(s);
      check("next_seq", dut_out(), pack(3'd4, RV, 3'd3, 2'd0, 1'b0));
    end

    s = idle(); s.redir = 1'b1; s.rpc = 32'h100;
    step(s);
    check("redirect", dut_out(), pack(3'd2, 32'h100, 3'd3, 2'd1, 1'b0));

    s = idle(); s.iv = 1'b1; s.acc = 1'b1;
    step(s);
    check("first_next_after_restart", dut_out(), pack(3'd4, 32'h100, 3'd3, 2'd1, 1'b0));

    s = idle(); s.trap = 1'b1; s.tpc = 32'h80; s.tmode = 3'd3; s.redir = 1'b1; s.rpc = 32'h444;
    step(s);
    check("trap_wins", dut_out(), pack(3'd2, 32'h80, 3'd3, 2'd2, 1'b0));
    step(idle());

    s = idle(); s.hreq = 1'b1; s.acc = 1'b1;
    step(s);
    s.acc = 1'b0;
    step(s);
    if (DBG_EN) begin
      check("halted", dut_out(), pack(3'd0, 32'h80, 3'd7, 2'd2, 1'b1));
      s.redir = 1'b1; s.rpc = 32'h999;
      step(s);
      check("halted_ignores_redirect", dut_out(), pack(3'd0, 32'h80, 3'd7, 2'd2, 1'b1));
      s = idle(); s.hreq = 1'b1; s.res = 1'b1; s.respc = 32'h200;
      step(s);
      check("resume", dut_out(), pack(3'd2, 32'h200, 3'd3, 2'd3, 1'b0));
      s.res = 1'b0;
      step(s);
      check("rehalt_after_restart", dut_out(), pack(3'd0, 32'h200, 3'd3, 2'd3, 1'b0));
    end else begin
      check("no_debug_halt", dut_out(), pack(3'd1, 32'h80, 3'd3, 2'd2, 1'b0));
    end

    // Tag wrap from a clean start: four redirects give 1,2,3,0.
    do_reset(1'b1);
    boot();
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.redir = 1'b1; s.rpc = 32'h1000 + 32'(i * 16);
      step(s);
      check("tag_wrap", dut_out(), pack(3'd2, 32'h1000 + 32'(i * 16), 3'd3, 2'((i + 1) % 4), 1'b0));
    end

    // Randomized traffic with one asynchronous reset in the middle.
    hold_req = 1'b0;
    for (int n = 0; n < 700; n++) begin
      if (n == 350) begin
        do_reset(1'b1);
        hold_req = 1'b0;
      end
      s = idle();
      s.iv    = ($urandom_range(0, 3) != 0);
      s.acc   = ($urandom_range(0, 2) != 0);
      s.blk   = ($urandom_range(0, 5) == 0);
      s.redir = ($urandom_range(0, 11) == 0);
      s.rpc   = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | 32'($urandom_range(0, 255) * 4);
      s.trap  = ($urandom_range(0, 19) == 0);
      s.tpc   = 32'($urandom_range(0, 1023) * 4);
      case ($urandom_range(0, 2))
        0:       s.tmode = 3'd0;
        1:       s.tmode = 3'd1;
        default: s.tmode = 3'd3;
      endcase
      if ($urandom_range(0, 24) == 0) hold_req = ~hold_req;
      s.hreq  = hold_req;
      s.res   = ($urandom_range(0, 7) == 0);
      s.respc = 32'($urandom_range(0, 4095) * 4);
      step(s);
    end

    apply(idle());
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
